// File: rtl/mod_sched.sv
// Round-robin scheduler that shares one iterative modulo core between two requesters.
// Sequences grant/load/iterate/complete and returns remainder or error with a one-cycle ack.
module mod_sched #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_ITER = 1024,
    parameter int unsigned ITER_W   = 11
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy,
    output logic             mod_load,
    output logic             mod_en,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    output logic [WIDTH-1:0] mod_sub,
    input  logic [WIDTH-1:0] mod_temp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    logic [1:0]        state,      state_d;
    logic              gid,        gid_d;
    logic              last_grant, last_grant_d;
    logic              zdiv,       zdiv_d;
    logic [ITER_W-1:0] cnt,        cnt_d;
    logic [WIDTH-1:0]  mod_a_d,    mod_b_d;
    logic [WIDTH-1:0]  result_d;
    logic              err_d;
    logic              ack0_d, ack1_d, busy_d, mod_load_d;
    logic              pick;

    // Subtractor feeding the core; wraps naturally at WIDTH bits.
    assign mod_sub = mod_temp - mod_b;

    // A tie goes to the requester that did not win last time.
    assign pick = (req0 && req1) ? ~last_grant : req1;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state;
        gid_d        = gid;
        last_grant_d = last_grant;
        zdiv_d       = zdiv;
        cnt_d        = cnt;
        mod_a_d      = mod_a;
        mod_b_d      = mod_b;
        result_d     = result;
        err_d        = err;
        mod_en       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    gid_d        = pick;
                    last_grant_d = pick;
                    mod_a_d      = pick ? a1 : a0;
                    mod_b_d      = pick ? b1 : b0;
                    zdiv_d       = (mod_b_d == '0);
                    cnt_d        = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                // A zero divisor spends this slot with the core untouched, then errors out.
                if (zdiv) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (mod_temp < mod_b) begin
                    result_d = mod_temp;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt < ITER_LIMIT) begin
                    mod_en = 1'b1;
                    cnt_d  = ITER_W'(cnt + 1'b1);
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mod_load_d = (state_d == S_LOAD) && !zdiv_d;
        busy_d     = (state_d != S_IDLE);
        ack0_d     = (state_d == S_DONE) && !gid_d;
        ack1_d     = (state_d == S_DONE) && gid_d;
    end

    // State and registered outputs; reset aborts any operation without an ack.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            gid        <= 1'b0;
            last_grant <= 1'b1;
            zdiv       <= 1'b0;
            cnt        <= '0;
            mod_a      <= '0;
            mod_b      <= '0;
            result     <= '0;
            err        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            mod_load   <= 1'b0;
        end else begin
            state      <= state_d;
            gid        <= gid_d;
            last_grant <= last_grant_d;
            zdiv       <= zdiv_d;
            cnt        <= cnt_d;
            mod_a      <= mod_a_d;
            mod_b      <= mod_b_d;
            result     <= result_d;
            err        <= err_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            busy       <= busy_d;
            mod_load   <= mod_load_d;
        end
    end

endmodule
